// File: rtl/uart_tx.sv
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8N1 / 8P1 UART transmitter, one bit per clock, registered line.
//             Optional two stop bits when UART_TX_TWO_STOP_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_TYP,
  input  logic                  PAR_EN,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int                 c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_parity;
  logic                  w_tx_next;
`ifdef UART_TX_TWO_STOP_EN
  logic                  r_stop_cnt;
`endif

  // Odd type is the XNOR-reduce, even type the XOR-reduce of the captured byte.
  always_comb begin
    w_parity = r_par_typ ? (^r_data) : (~^r_data);
  end

  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      c_START:  w_tx_next = 1'b0;
      c_DATA:   w_tx_next = r_data[r_cnt];
      c_PARITY: w_tx_next = w_parity;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:   if (Data_Valid) w_state_next = c_START;
      c_START:  w_state_next = c_DATA;
      c_DATA:   if (r_cnt == c_LAST) w_state_next = r_par_en ? c_PARITY : c_STOP;
      c_PARITY: w_state_next = c_STOP;
`ifdef UART_TX_TWO_STOP_EN
      c_STOP:   if (r_stop_cnt) w_state_next = c_IDLE;
`else
      c_STOP:   w_state_next = c_IDLE;
`endif
      default:  w_state_next = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop_cnt <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      // Busy follows the state by one cycle, matching the line register.
      r_busy  <= (r_state != c_IDLE);
      if ((r_state == c_IDLE) && Data_Valid) begin
        r_data    <= P_DATA;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
      end
      if (r_state == c_DATA)
        r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
      else
        r_cnt <= '0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop_cnt <= (r_state == c_STOP) ? ~r_stop_cnt : 1'b0;
`endif
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed self-checking bench for uart_tx.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic       PAR_TYP;
  logic       PAR_EN;
  logic       Data_Valid;
  logic [7:0] P_DATA;
  logic       TX_OUT;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_TYP    (PAR_TYP),
    .PAR_EN     (PAR_EN),
    .Data_Valid (Data_Valid),
    .P_DATA     (P_DATA),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Sends one frame and checks every line bit and Busy from E0 to idle.
  // When disturb is set, a second request with other data/config is
  // driven so that it is sampled at E5.
  task automatic frame(input string tag, input logic [7:0] d, input logic en,
                       input logic typ, input logic exp_par, input logic disturb);
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    chk({tag, "_e0_tx"}, TX_OUT, 1'b1);
    chk({tag, "_e0_busy"}, Busy, 1'b0);
    tick();
    chk({tag, "_start_tx"}, TX_OUT, 1'b0);
    chk({tag, "_start_busy"}, Busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (disturb && i == 3) begin
        Data_Valid = 1'b1; P_DATA = 8'h55; PAR_EN = ~en; PAR_TYP = ~typ;
      end else begin
        Data_Valid = 1'b0;
      end
      tick();
      chk($sformatf("%s_d%0d_tx", tag, i), TX_OUT, d[i]);
      chk($sformatf("%s_d%0d_busy", tag, i), Busy, 1'b1);
    end
    Data_Valid = 1'b0;
    if (en) begin
      tick();
      chk({tag, "_par_tx"}, TX_OUT, exp_par);
      chk({tag, "_par_busy"}, Busy, 1'b1);
    end
    tick();
    chk({tag, "_stop_tx"}, TX_OUT, 1'b1);
    chk({tag, "_stop_busy"}, Busy, 1'b1);
`ifdef UART_TX_TWO_STOP_EN
    tick();
    chk({tag, "_stop2_tx"}, TX_OUT, 1'b1);
    chk({tag, "_stop2_busy"}, Busy, 1'b1);
`endif
    tick();
    chk({tag, "_idle_tx"}, TX_OUT, 1'b1);
    chk({tag, "_idle_busy"}, Busy, 1'b0);
  endtask

  initial begin
    RST = 1'b1; PAR_TYP = 1'b0; PAR_EN = 1'b0; Data_Valid = 1'b0; P_DATA = 8'h00;
    #2;
    RST = 1'b0;
    #1;
    chk("rst_tx", TX_OUT, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    tick();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle%0d_tx", i), TX_OUT, 1'b1);
      chk($sformatf("idle%0d_busy", i), Busy, 1'b0);
    end

    // 0xBB without parity
    frame("nopar_bb", 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
    // 0x8E has four ones, 0x3B has five
    frame("odd_8e",  8'h8E, 1'b1, 1'b0, 1'b1, 1'b0);
    frame("odd_3b",  8'h3B, 1'b1, 1'b0, 1'b0, 1'b0);
    frame("even_8e", 8'h8E, 1'b1, 1'b1, 1'b0, 1'b0);
    frame("even_3b", 8'h3B, 1'b1, 1'b1, 1'b1, 1'b0);

    // mid-frame request and config change must be ignored
    frame("ignore_a3", 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("noq%0d_tx", i), TX_OUT, 1'b1);
      chk($sformatf("noq%0d_busy", i), Busy, 1'b0);
    end

    // back-to-back: next request accepted right after the idle edge
    frame("b2b_0f", 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    frame("b2b_c6", 8'hC6, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset at E4 of a frame carrying 0xF0 (bit 2 = 0 on the line)
    P_DATA = 8'hF0; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("prerst_tx", TX_OUT, 1'b0);
    chk("prerst_busy", Busy, 1'b1);
    RST = 1'b0;
    #1;
    chk("midrst_tx", TX_OUT, 1'b1);
    chk("midrst_busy", Busy, 1'b0);
    tick();
    RST = 1'b1;
    tick();
    chk("postrst_tx", TX_OUT, 1'b1);
    chk("postrst_busy", Busy, 1'b0);
    frame("after_rst_1d", 8'h1D, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter with an 8-bit parallel load and a 1-bit serial output.
- One beat on Data_Valid starts a frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- One bit per clock; baud rate equals the clock, with no internal baud divider.
- Used as the top-level transmit block. Internally it contains the FSM, serializer, parity calculator, output mux and an output register.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame. Only the value 8 is verified.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- PAR_TYP  input  1  parity type. 0 = odd parity: bit is the XNOR-reduce of the data. 1 = even parity: bit is the XOR-reduce of the data.
- PAR_EN  input  1  1 = insert a parity bit after the data bits.
- Data_Valid  input  1  one-cycle request to send P_DATA.
- P_DATA  input  DATA_WIDTH  parallel data to transmit.
- TX_OUT  output  1  serial line; idle high; registered.
- Busy  output  1  high while a frame is on TX_OUT; registered.

Behaviour:
- Reset (RST=0, asynchronous):
  - TX_OUT=1, Busy=0.
  - FSM goes to IDLE; bit counter, data register and parity config cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Sampling Data_Valid=1 on a rising edge (call it E0) captures P_DATA, PAR_EN and PAR_TYP into internal registers and moves to START.
  - The captured values are used for the whole frame. Input changes after E0 have no effect.
- Data_Valid is ignored in every state except IDLE; there is no queueing.
- Transitions:
  - START -> DATA after 1 cycle.
  - DATA lasts 8 cycles, bit counter 0..7, sending data[0] first.
  - After the last data bit: PARITY if captured PAR_EN=1, otherwise STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> IDLE after 1 cycle.
- Output mux by current state: IDLE=1, START=0, DATA=data[cnt], PARITY=parity bit, STOP=1. The mux feeds the TX_OUT register, so the line lags the state by one cycle.
- Line timing relative to E0:
  - TX_OUT=0 (start bit) from E1.
  - data[i] from E(2+i), i = 0..7.
  - With parity: parity bit from E10, stop from E11, back to idle-high from E12.
  - Without parity: stop from E10, idle from E11.
- Busy register is loaded with (state != IDLE). Busy therefore rises at E1 and falls on the same edge that TX_OUT returns to idle, so it covers exactly start through stop.
- Parity is computed from the captured data: PAR_TYP=0 gives ~^data, PAR_TYP=1 gives ^data.
- Back-to-back frames:
  - The earliest next Data_Valid is accepted on the edge after STOP, i.e. while in IDLE.
  - Minimum frame spacing: 11 cycles without parity, 12 with parity.
  - There is no idle gap requirement beyond the stop bit.
- Data_Valid held high for several cycles: only the first edge in IDLE is accepted. If it is still high when the FSM next reaches IDLE, a new frame starts.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 cycles, so TX_OUT is high for 2 bit times. Busy is held through both. Minimum frame spacing grows by 1.
- Undefined: a single stop bit as described above.

Test Plan:
- Reset then idle: RST low for 1 cycle, then held high for 3 cycles -> TX_OUT=1, Busy=0 throughout.
- No parity: P_DATA=0xBB, PAR_EN=0, Data_Valid pulse -> TX_OUT 0 at E1; bits 1,1,0,1,1,1,0,1 at E2..E9; 1 at E10; Busy high E1..E10.
- Parity enabled, odd-type: 0x8E with PAR_EN=1, PAR_TYP=0 -> parity bit 1 at E10, stop at E11. Repeat with 0x3B -> parity bit 0.
- Parity enabled, even-type: 0x8E with PAR_TYP=1 -> parity bit 0. Repeat with 0x3B -> parity bit 1.
- Ignored inputs mid-frame: pulse Data_Valid with 0x55 at E5, and change P_DATA/PAR_EN during the frame -> the frame still carries the original data; no second frame.
- Reset at E4 of a frame -> TX_OUT=1 and Busy=0 immediately. The next Data_Valid with 0x1D, PAR_TYP=1, PAR_EN=0 transmits cleanly.
